// File: rtl/cla_pipelined_adder.sv
// cla_pipelined_adder
// Two-stage pipelined carry-lookahead adder built from 4-bit CLA groups.
//   Stage 1 registers the bit propagate/generate vectors, the per-group
//   propagate/generate (BP/BG per group) and the effective carry-in.
//   Stage 2 resolves the group carries from the stage-1 registers, expands
//   them into intra-group carries with flat lookahead equations, and
//   registers the results.
//
// Optional feature: define CLA_SUB_EN to add the 'sub' input, which turns the
// operation into a - b (b complemented, effective carry-in forced to 1).
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operands a, b, cin (and sub) valid this cycle
//   in_ready   stage 1 can accept operands
//   a, b       operands, WIDTH bits
//   cin        carry-in (ignored when sub=1)
//   sub        (CLA_SUB_EN only) 1 = subtract
//   out_valid  result registers hold a valid result
//   out_ready  consumer accepts the result this cycle
//   sum        registered sum, modulo 2^WIDTH
//   cout       registered carry-out (for subtraction: 1 = no borrow)
//   ovf        registered signed overflow
//   BP         registered whole-word propagate
//   BG         registered whole-word generate (carry out with cin=0)

module cla_pipelined_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             BP,
  output logic             BG
);

  localparam int NG = WIDTH / 4;

  // Stage-1 registers
  logic             s1_valid;
  logic [WIDTH-1:0] s1_p;
  logic [WIDTH-1:0] s1_g;
  logic [NG-1:0]    s1_bp;
  logic [NG-1:0]    s1_bg;
  logic             s1_cin;

  logic s1_load;
  logic s2_load;

  assign in_ready = !s1_valid || !out_valid || out_ready;
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s1_valid && (!out_valid || out_ready);

  // Stage-1 combinational: operand conditioning and group P/G
  logic [WIDTH-1:0] b_eff;
  logic             cin_d;
  logic [WIDTH-1:0] p_d;
  logic [WIDTH-1:0] g_d;
  logic [NG-1:0]    bp_d;
  logic [NG-1:0]    bg_d;

  always_comb begin
    b_eff = b;
    cin_d = cin;
`ifdef CLA_SUB_EN
    if (sub) begin
      b_eff = ~b;
      cin_d = 1'b1;
    end
`endif
    p_d  = a ^ b_eff;
    g_d  = a & b_eff;
    bp_d = '0;
    bg_d = '0;
    for (int k = 0; k < NG; k++) begin
      bp_d[k] = &p_d[4*k +: 4];
      bg_d[k] = g_d[4*k+3]
              | (p_d[4*k+3] & g_d[4*k+2])
              | (p_d[4*k+3] & p_d[4*k+2] & g_d[4*k+1])
              | (p_d[4*k+3] & p_d[4*k+2] & p_d[4*k+1] & g_d[4*k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_g     <= '0;
      s1_bp    <= '0;
      s1_bg    <= '0;
      s1_cin   <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_p     <= p_d;
        s1_g     <= g_d;
        s1_bp    <= bp_d;
        s1_bg    <= bg_d;
        s1_cin   <= cin_d;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage-2 combinational: group carries, then intra-group lookahead.
  // gz is the same group recurrence seeded with 0, giving the word generate.
  logic [NG:0]      gc;
  logic [NG:0]      gz;
  logic [WIDTH-1:0] bc;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;

  always_comb begin
    gc    = '0;
    gz    = '0;
    bc    = '0;
    gc[0] = s1_cin;
    for (int k = 0; k < NG; k++) begin
      gc[k+1] = s1_bg[k] | (s1_bp[k] & gc[k]);
      gz[k+1] = s1_bg[k] | (s1_bp[k] & gz[k]);
    end
    for (int k = 0; k < NG; k++) begin
      bc[4*k]   = gc[k];
      bc[4*k+1] = s1_g[4*k]
                | (s1_p[4*k] & gc[k]);
      bc[4*k+2] = s1_g[4*k+1]
                | (s1_p[4*k+1] & s1_g[4*k])
                | (s1_p[4*k+1] & s1_p[4*k] & gc[k]);
      bc[4*k+3] = s1_g[4*k+2]
                | (s1_p[4*k+2] & s1_g[4*k+1])
                | (s1_p[4*k+2] & s1_p[4*k+1] & s1_g[4*k])
                | (s1_p[4*k+2] & s1_p[4*k+1] & s1_p[4*k] & gc[k]);
    end
    sum_d  = s1_p ^ bc;
    cout_d = gc[NG];
    // carry into the MSB vs carry out of it
    ovf_d  = bc[WIDTH-1] ^ gc[NG];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      BP        <= 1'b0;
      BG        <= 1'b0;
    end else begin
      if (s2_load) begin
        out_valid <= 1'b1;
        sum       <= sum_d;
        cout      <= cout_d;
        ovf       <= ovf_d;
        BP        <= &s1_bp;
        BG        <= gz[NG];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cla_pipelined_adder.sv
module tb_cla_pipelined_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         BP;
  logic         BG;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cla_pipelined_adder #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .cin(cin),
`ifdef CLA_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum(sum),
    .cout(cout),
    .ovf(ovf),
    .BP(BP),
    .BG(BG)
  );

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    logic         bp;
    logic         bg;
  } res_t;

  // Arithmetic model: plain integer addition on widened operands.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sb);
    res_t r;
    logic [W-1:0] yy;
    logic         c0;
    logic [W:0]   full;
    logic [W:0]   nocarry;
    yy      = sb ? ~y : y;
    c0      = sb ? 1'b1 : ci;
    full    = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, c0};
    nocarry = {1'b0, x} + {1'b0, yy};
    r.s  = full[W-1:0];
    r.co = full[W];
    r.ov = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
    r.bp = ((x ^ yy) == {W{1'b1}});
    r.bg = nocarry[W];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic res_t dut_res();
    res_t r;
    r.s = sum; r.co = cout; r.ov = ovf; r.bp = BP; r.bg = BG;
    return r;
  endfunction

  // Scoreboard: push on accept, pop on drain, check holds during stalls.
  res_t q[$];
  res_t held;
  logic prev_stall = 1'b0;
  int   drained = 0;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_data", {11'd0, dut_res()}, {11'd0, held});
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          chk("stream_result", {11'd0, dut_res()}, {11'd0, q.pop_front()});
          drained++;
        end
      end
      prev_stall = out_valid && !out_ready;
      held = dut_res();
      if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
    end
  end

  // Single op with idle pipeline; checks latency, literal values and one-cycle valid.
  task automatic single(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic sb, input res_t exp);
    int n;
    chk({name, "_model"}, {11'd0, model(x, y, ci, sb)}, {11'd0, exp});
    @(posedge clk); #1;
    a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    chk({name, "_latency"}, n, 2);
    chk({name, "_value"}, {11'd0, dut_res()}, {11'd0, exp});
    @(negedge clk);
    chk({name, "_one_cycle"}, {31'd0, out_valid}, 32'd0);
  endtask

  logic [W-1:0] bp_a [3] = '{16'h1111, 16'h2222, 16'h0F0F};
  logic [W-1:0] bp_b [3] = '{16'h0001, 16'h0002, 16'h0101};

  initial begin
    int idx, cnt, first, last, n;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    #12;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out", {30'd0, out_valid, (sum == '0 && !cout && !ovf && !BP && !BG)}, 32'd1);
    @(negedge clk); rst = 1'b0;
    chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

    single("t_00ff", 16'h00FF, 16'h0001, 1'b0, 1'b0, '{16'h0100, 1'b0, 1'b0, 1'b0, 1'b0});
    single("t_ffff_cin", 16'hFFFF, 16'h0000, 1'b1, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0});
    single("t_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b0, 1'b1});
    single("t_7fff", 16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b0, 1'b0});
    single("t_8000", 16'h8000, 16'h8000, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1, 1'b0, 1'b1});

    // Back-to-back stream of 8
    cnt = 0; first = -1; last = -1;
    @(posedge clk); #1;
    for (int c = 0; c < 14; c++) begin
      in_valid = (c < 8);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      @(negedge clk);
      if (c < 8) chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
      if (out_valid) begin
        cnt++;
        if (first < 0) first = c;
        last = c;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("stream_count", cnt, 8);
    chk("stream_contiguous", last - first, 7);

    // Backpressure
    out_ready = 1'b0; idx = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = (idx < 3); a = bp_a[idx % 3]; b = bp_b[idx % 3]; cin = 1'b0;
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
    end
    chk("bp_accepted", idx, 2);
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1; n = 0;
    while (idx < 3 && n < 10) begin
      in_valid = 1'b1; a = bp_a[idx]; b = bp_b[idx];
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    chk("bp_third_accepted", idx, 3);
    n = 0;
    while (q.size() != 0 && n < 10) begin @(posedge clk); n++; end
    chk("bp_drained", q.size(), 0);

    // Async reset mid-stream
    drained = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; a = 16'h0123; b = 16'h0456; cin = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_reset_valid", {31'd0, out_valid}, 32'd0);
    chk("async_reset_sum", {16'd0, sum}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk); #2;
    rst = 1'b0;
    chk("after_reset_in_ready", {31'd0, in_ready}, 32'd1);
    single("t_5p1", 16'h0005, 16'h0001, 1'b0, 1'b0, '{16'h0006, 1'b0, 1'b0, 1'b0, 1'b0});
`ifdef CLA_SUB_EN
    single("t_sub", 16'h0003, 16'h0005, 1'b0, 1'b1, '{16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0});
    single("t_sub_nb", 16'h0005, 16'h0003, 1'b1, 1'b1, '{16'h0002, 1'b1, 1'b0, 1'b0, 1'b1});
    single("t_sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1});
`endif
    repeat (3) @(posedge clk);
    chk("final_queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
